// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download router and related loaders.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold,
        StReady
    } dl_state_e;

    localparam logic [26:0] GFX_BASE_DEFAULT = 27'h8000;
    localparam int unsigned BYTE_COUNT_W     = 17;
    localparam int unsigned CHECKSUM_W       = 16;

endpackage

// File: rtl/wr_edge_detect.sv
// Registered rising-edge detector for an ioctl-style write request, gated by an enable.
module wr_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr_i,
    input  logic en_i,
    output logic edge_o
);

    logic wr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= wr_i;
        end
    end

    assign edge_o = wr_i & ~wr_q & en_i;

endmodule

// File: rtl/rom_download_router.sv
// Routes the ioctl download byte stream to CPU/GFX ROM write ports, holds the CPU in reset
// until a load completes, and tracks byte count and checksum of the load.
module rom_download_router
    import rom_dl_pkg::*;
#(
    parameter int unsigned CPU_AW      = 15,
    parameter logic [26:0] GFX_BASE    = GFX_BASE_DEFAULT,
    parameter int unsigned GFX_AW      = 14,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic [26:0]             ioctl_addr,
    input  logic [7:0]              ioctl_dout,
    input  logic                    ioctl_wr,
    output logic [CPU_AW-1:0]       cpu_rom_addr,
    output logic [7:0]              cpu_rom_dout,
    output logic                    cpu_rom_wr,
    output logic [GFX_AW-1:0]       gfx_rom_addr,
    output logic [7:0]              gfx_rom_dout,
    output logic                    gfx_rom_wr,
    output logic                    cpu_hold,
    output logic                    rom_ready,
    output logic                    range_err,
    output logic [BYTE_COUNT_W-1:0] byte_count,
    output logic [CHECKSUM_W-1:0]   checksum
);

    localparam int unsigned HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [27:0] CpuLimit = 28'd1 << CPU_AW;
    localparam logic [27:0] GfxLo    = {1'b0, GFX_BASE};
    localparam logic [27:0] GfxHi    = GfxLo + (28'd1 << GFX_AW);

    logic wr_edge;

    wr_edge_detect u_wr_edge (
        .clk_i  (clk_sys),
        .rst_i  (reset),
        .wr_i   (ioctl_wr),
        .en_i   (ioctl_download),
        .edge_o (wr_edge)
    );

    // Region decode; CPU wins if the regions were ever configured to overlap.
    logic [27:0] addr_ext;
    logic        hit_cpu, hit_gfx, accept;

    assign addr_ext = {1'b0, ioctl_addr};
    assign hit_cpu  = addr_ext < CpuLimit;
    assign hit_gfx  = ~hit_cpu && (addr_ext >= GfxLo) && (addr_ext < GfxHi);
    assign accept   = wr_edge & (hit_cpu | hit_gfx);

    dl_state_e         state_q, state_d;
    logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
    logic              load_entry;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: if (ioctl_download) state_d = StLoad;
            StLoad: begin
                if (!ioctl_download) begin
                    state_d    = StHold;
                    hold_cnt_d = HoldW'(HOLD_CYCLES - 1);
                end
            end
            StHold: begin
                if (ioctl_download) begin
                    state_d = StLoad;
                end else if (hold_cnt_q == '0) begin
                    state_d = StReady;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            StReady: if (ioctl_download) state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    assign load_entry = (state_d == StLoad) && (state_q != StLoad);

    logic [CPU_AW-1:0]       cpu_addr_d;
    logic [7:0]              cpu_dout_d, gfx_dout_d;
    logic [GFX_AW-1:0]       gfx_addr_d;
    logic                    cpu_wr_d, gfx_wr_d, range_err_d, range_err_base;
    logic [BYTE_COUNT_W-1:0] count_base, count_d;
    logic [CHECKSUM_W-1:0]   sum_base, sum_d;

    // Counters restart on load entry; a write arriving in that same cycle still counts.
    always_comb begin
        cpu_addr_d     = cpu_rom_addr;
        cpu_dout_d     = cpu_rom_dout;
        gfx_addr_d     = gfx_rom_addr;
        gfx_dout_d     = gfx_rom_dout;
        cpu_wr_d       = wr_edge & hit_cpu;
        gfx_wr_d       = wr_edge & hit_gfx;
        count_base     = load_entry ? '0 : byte_count;
        sum_base       = load_entry ? '0 : checksum;
        range_err_base = load_entry ? 1'b0 : range_err;
        count_d        = count_base;
        sum_d          = sum_base;
        range_err_d    = range_err_base | (wr_edge & ~hit_cpu & ~hit_gfx);
        if (cpu_wr_d) begin
            cpu_addr_d = ioctl_addr[CPU_AW-1:0];
            cpu_dout_d = ioctl_dout;
        end
        if (gfx_wr_d) begin
            gfx_addr_d = ioctl_addr[GFX_AW-1:0] - GFX_BASE[GFX_AW-1:0];
            gfx_dout_d = ioctl_dout;
        end
        if (accept) begin
            if (count_base != '1) count_d = count_base + 1'b1;
            sum_d = sum_base + {8'h00, ioctl_dout};
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            hold_cnt_q   <= '0;
            cpu_rom_addr <= '0;
            cpu_rom_dout <= '0;
            cpu_rom_wr   <= 1'b0;
            gfx_rom_addr <= '0;
            gfx_rom_dout <= '0;
            gfx_rom_wr   <= 1'b0;
            range_err    <= 1'b0;
            byte_count   <= '0;
            checksum     <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cpu_rom_addr <= cpu_addr_d;
            cpu_rom_dout <= cpu_dout_d;
            cpu_rom_wr   <= cpu_wr_d;
            gfx_rom_addr <= gfx_addr_d;
            gfx_rom_dout <= gfx_dout_d;
            gfx_rom_wr   <= gfx_wr_d;
            range_err    <= range_err_d;
            byte_count   <= count_d;
            checksum     <= sum_d;
        end
    end

    assign cpu_hold  = (state_q != StReady);
    assign rom_ready = (state_q == StReady);

endmodule

// File: doc/rom_download_router.md
Name: rom_download_router

Overview:
- Upstream stage that sits between the data_io ioctl download stream and the on-chip ROM stores (CPU program ROM, graphics ROM).
- Splits the byte stream into per-region write ports with region-relative addresses.
- Turns multi-cycle ioctl_wr assertions into single-cycle write strobes.
- Holds the CPU in reset until a download has completed, then tracks byte count and checksum for load verification.

Parameters:
- CPU_AW, 15, CPU ROM address width; region occupies ioctl_addr [0, 2^CPU_AW).
- GFX_BASE, 27'h8000, first ioctl_addr of the graphics region.
- GFX_AW, 14, graphics ROM address width; region is [GFX_BASE, GFX_BASE+2^GFX_AW).
- HOLD_CYCLES, 16, clk_sys cycles cpu_hold stays high after the download ends.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download in progress
- ioctl_addr  in  27  byte address of the download stream
- ioctl_dout  in  8  download data byte
- ioctl_wr  in  1  write request; may stay high for several cycles
- cpu_rom_addr  out  CPU_AW  CPU ROM write address
- cpu_rom_dout  out  8  CPU ROM write data
- cpu_rom_wr  out  1  CPU ROM write strobe, one cycle wide
- gfx_rom_addr  out  GFX_AW  graphics ROM write address (addr - GFX_BASE)
- gfx_rom_dout  out  8  graphics ROM write data
- gfx_rom_wr  out  1  graphics ROM write strobe, one cycle wide
- cpu_hold  out  1  CPU reset request, active high
- rom_ready  out  1  at least one download completed and hold released
- range_err  out  1  sticky: a write fell outside both regions during the current load
- byte_count  out  17  accepted writes in the current or last load
- checksum  out  16  modulo-2^16 sum of accepted bytes

Behaviour:
- Reset values: all *_wr=0, all addr/dout=0, cpu_hold=1, rom_ready=0, range_err=0, byte_count=0, checksum=0, state=IDLE.
- Write-edge detect: register ioctl_wr into wr_q. wr_edge = ioctl_wr & ~wr_q & ioctl_download.
  - Exactly one strobe per low->high transition.
  - A continuously held ioctl_wr produces one strobe.
- Write latency: on wr_edge at cycle N, the region decode registers addr/dout and pulses the matching *_wr high for cycle N+1 only.
  - CPU region: addr < 2^CPU_AW.
  - GFX region: GFX_BASE <= addr < GFX_BASE+2^GFX_AW.
  - Regions are disjoint by construction; CPU takes priority if misconfigured.
  - Addr/dout outputs hold their last value when no strobe is issued.
- Out-of-range write: no strobe, range_err set, byte_count/checksum unchanged.
- Accepted write: byte_count += 1, saturating at 2^17-1; checksum += dout, wrapping. Both are updated in the same cycle as the strobe.
- FSM states: IDLE, LOAD, HOLD, READY.
  - IDLE: cpu_hold=1, rom_ready=0. ioctl_download=1 -> LOAD.
  - Entry to LOAD from any state: clear byte_count, checksum and range_err; rom_ready=0; cpu_hold=1.
  - LOAD: ioctl_download=0 -> HOLD; load hold counter with HOLD_CYCLES-1.
  - HOLD: cpu_hold=1; counter decrements each cycle. At 0 -> READY. ioctl_download=1 -> LOAD (abort hold).
  - READY: cpu_hold=0, rom_ready=1. ioctl_download=1 -> LOAD.
- Simultaneous events:
  - An edge on the last cycle of ioctl_download is still accepted.
  - Edges while ioctl_download=0 are ignored.
- Reset mid-load: everything returns to reset values immediately. Any strobe in flight is dropped. ROM contents are not the block's concern.
- Reset mid-hold: back to IDLE; cpu_hold stays high.

Decomposition:
- Shared package (rom_dl_pkg):
  - state enum (IDLE, LOAD, HOLD, READY)
  - default GFX_BASE constant
  - byte_count and checksum widths
- One natural sub-module, wr_edge_detect: registered ioctl_wr rising-edge detector gated by download. Reusable by other loaders in the codebase.

Test Plan:
- Reset, no download for 100 cycles -> cpu_hold=1, rom_ready=0, no strobes.
- Download addr 0x0000..0x0003 with data 01,02,03,04, each wr held 3 cycles -> exactly 4 cpu_rom_wr pulses, each one cycle after its edge, with addr 0..3. Then byte_count=4, checksum=0x000A.
- Write addr 0x8005 data 0xAA -> gfx_rom_wr pulse, gfx_rom_addr=0x0005, gfx_rom_dout=0xAA, cpu_rom_wr stays 0. Write addr 0xC000 -> no strobe, range_err=1, byte_count unchanged.
- Download falls -> cpu_hold high for exactly 16 cycles, then cpu_hold=0 and rom_ready=1 on the same edge.
- Download reasserted 5 cycles into HOLD -> state LOAD; counters and range_err cleared; cpu_hold stays 1; rom_ready stays 0.
- Assert reset during LOAD with a wr edge on the same cycle -> no strobe in the next cycle; all outputs at reset values; state IDLE.
